// File: rtl/cpu_types_pkg.sv
// Types shared by the cache-to-RAM path: data words, the RAM handshake
// encoding and the arbiter FSM state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

endpackage

// File: rtl/arb_picker.sv
// Combinational winner selection: walks the CPUs starting at rr and takes the
// first one with any request; within a CPU the dcache beats the icache.
module arb_picker #(
  parameter int CPUS = 2,
  localparam int CW = (CPUS > 1) ? $clog2(CPUS) : 1
) (
  input  logic [CPUS-1:0] ireq,
  input  logic [CPUS-1:0] dreq,
  input  logic [CW-1:0]   rr,
  output logic            valid,
  output logic [CW-1:0]   cpu,
  output logic            src
);

  logic [CW:0]   idx;
  logic [CW-1:0] sel;

  always_comb begin
    valid = 1'b0;
    cpu   = '0;
    src   = 1'b0;
    idx   = '0;
    sel   = '0;
    for (int k = 0; k < CPUS; k++) begin
      // rr + k wrapped into 0..CPUS-1 without a modulo operator
      idx = {1'b0, rr} + (CW+1)'(k);
      if (idx >= (CW+1)'(CPUS)) begin
        idx = idx - (CW+1)'(CPUS);
      end
      sel = idx[CW-1:0];
      if (!valid && (dreq[sel] || ireq[sel])) begin
        valid = 1'b1;
        cpu   = sel;
        src   = dreq[sel];
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one RAM port between the icache/dcache of every CPU, one transaction
// at a time. Define ARB_RR_EN for round-robin across CPUs; otherwise cpu 0 first.
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS = 2,
  localparam int CW = (CPUS > 1) ? $clog2(CPUS) : 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [CPUS-1:0]       iREN,
  input  logic [CPUS-1:0][31:0] iaddr,
  output logic [CPUS-1:0]       iwait,
  output logic [CPUS-1:0][31:0] iload,
  input  logic [CPUS-1:0]       dREN,
  input  logic [CPUS-1:0]       dWEN,
  input  logic [CPUS-1:0][31:0] daddr,
  input  logic [CPUS-1:0][31:0] dstore,
  output logic [CPUS-1:0]       dwait,
  output logic [CPUS-1:0][31:0] dload,
  output logic                  ramREN,
  output logic                  ramWEN,
  output logic [31:0]           ramaddr,
  output logic [31:0]           ramstore,
  input  logic [31:0]           ramload,
  input  logic [1:0]            ramstate
);

  arb_state_t    state_reg;
  logic          src_reg;
  logic [CW-1:0] cpu_reg;
  word_t         addr_reg;
  word_t         store_reg;
  logic          ren_reg;
  logic          wen_reg;

  logic          pick_valid;
  logic [CW-1:0] pick_cpu;
  logic          pick_src;
  logic [CW-1:0] pick_rr;

  logic          in_xfer;
  logic          held;
  logic          complete;
  logic          withdrawn;

  arb_picker #(.CPUS(CPUS)) u_picker (
    .ireq  (iREN),
    .dreq  (dREN | dWEN),
    .rr    (pick_rr),
    .valid (pick_valid),
    .cpu   (pick_cpu),
    .src   (pick_src)
  );

  // The winner keeps its transaction only while its own strobe stays high.
  assign in_xfer   = (state_reg == XFER);
  assign held      = src_reg ? (wen_reg ? dWEN[cpu_reg] : dREN[cpu_reg])
                             : iREN[cpu_reg];
  assign complete  = in_xfer && held && (ramstate_t'(ramstate) == ACCESS);
  assign withdrawn = in_xfer && !held;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= IDLE;
      src_reg   <= 1'b0;
      cpu_reg   <= '0;
      addr_reg  <= '0;
      store_reg <= '0;
      ren_reg   <= 1'b0;
      wen_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            state_reg <= XFER;
            src_reg   <= pick_src;
            cpu_reg   <= pick_cpu;
            addr_reg  <= pick_src ? daddr[pick_cpu] : iaddr[pick_cpu];
            store_reg <= (pick_src && dWEN[pick_cpu]) ? dstore[pick_cpu] : '0;
            ren_reg   <= !(pick_src && dWEN[pick_cpu]);
            wen_reg   <= pick_src && dWEN[pick_cpu];
          end
        end
        XFER: begin
          // ERROR/BUSY/FREE simply hold; the RAM outputs clear on exit.
          if (complete || withdrawn) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            store_reg <= '0;
            ren_reg   <= 1'b0;
            wen_reg   <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ramREN   = ren_reg;
  assign ramWEN   = wen_reg;
  assign ramaddr  = addr_reg;
  assign ramstore = store_reg;

`ifdef ARB_RR_EN
  logic [CW-1:0] rr_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_reg <= '0;
    end else if (complete) begin
      rr_reg <= (cpu_reg == CW'(CPUS - 1)) ? '0 : cpu_reg + CW'(1);
    end
  end

  assign pick_rr = rr_reg;
`else
  assign pick_rr = '0;
`endif

  for (genvar gi = 0; gi < CPUS; gi++) begin : g_cpu
    logic  mine;
    logic  fill_i;
    logic  fill_d;
    word_t iload_reg;
    word_t dload_reg;

    assign mine   = complete && (cpu_reg == CW'(gi));
    assign fill_i = mine && !src_reg;
    assign fill_d = mine && src_reg && !wen_reg;

    assign iwait[gi] = !(mine && !src_reg);
    assign dwait[gi] = !(mine && src_reg);

    always_ff @(posedge CLK) begin
      if (RST) begin
        iload_reg <= '0;
        dload_reg <= '0;
      end else begin
        if (fill_i) iload_reg <= ramload;
        if (fill_d) dload_reg <= ramload;
      end
    end

    // Read data reaches the cache in the completion cycle itself.
    assign iload[gi] = fill_i ? ramload : iload_reg;
    assign dload[gi] = fill_d ? ramload : dload_reg;
  end

endmodule
